// File: rtl/cond_flag_unit.sv
// cond_flag_unit
// Condition/flag stage downstream of the 16-bit ALU in the multicycle CPU.
// Registers the ALU result, keeps the NZCV status register, evaluates the
// ARM-style condition field against the stored flags and gates the
// controller's write strobes with the latched condition result.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   alu_result  ALU result, captured into alu_out every cycle
//   n_in..v_in  ALU flag outputs
//   cond        4-bit condition field of the current instruction
//   cond_latch  Decode pulse: latch condition-pass into cond_ex
//   flag_w      [1] update N,Z  [0] update C,V (only when cond_ex=1)
//   pc_update   unconditional PC write
//   pc_s        conditional PC write
//   reg_w       conditional register-file write
//   mem_w       conditional memory write
//   no_write    compare-type op, suppresses register write
//   alu_out     registered ALU result
//   flags       stored status {N,Z,C,V}
//   cond_ex     latched condition-pass
//   pc_write, reg_write, mem_write  gated write strobes
module cond_flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic [3:0]       cond,
  input  logic             cond_latch,
  input  logic [1:0]       flag_w,
  input  logic             pc_update,
  input  logic             pc_s,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             cond_ex,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_write
);

  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q, flags_d;
  logic             cond_ex_q, cond_ex_d;
  logic             cond_pass;

  // Stored flag bits, {N,Z,C,V}
  logic f_n, f_z, f_c, f_v;
  assign f_n = flags_q[3];
  assign f_z = flags_q[2];
  assign f_c = flags_q[1];
  assign f_v = flags_q[0];

  // Condition evaluated on the stored flags, never on the live ALU flags.
  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'h0:    cond_pass = f_z;
      4'h1:    cond_pass = ~f_z;
      4'h2:    cond_pass = f_c;
      4'h3:    cond_pass = ~f_c;
      4'h4:    cond_pass = f_n;
      4'h5:    cond_pass = ~f_n;
      4'h6:    cond_pass = f_v;
      4'h7:    cond_pass = ~f_v;
      4'h8:    cond_pass = f_c & ~f_z;
      4'h9:    cond_pass = ~f_c | f_z;
      4'hA:    cond_pass = (f_n == f_v);
      4'hB:    cond_pass = (f_n != f_v);
      4'hC:    cond_pass = ~f_z & (f_n == f_v);
      4'hD:    cond_pass = f_z | (f_n != f_v);
      default: cond_pass = 1'b1;  // AL and the unused 0xF encoding
    endcase
  end

  // Flag writes are gated by the currently held cond_ex, so a cond_latch in
  // the same cycle neither enables nor blocks this cycle's flag write.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (cond_latch) begin
      cond_ex_d = cond_pass;
    end
    if (cond_ex_q && flag_w[1]) begin
      flags_d[3] = n_in;
      flags_d[2] = z_in;
    end
    if (cond_ex_q && flag_w[0]) begin
      flags_d[1] = c_in;
      flags_d[0] = v_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out_q <= '0;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      alu_out_q <= alu_result;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;
  assign cond_ex = cond_ex_q;

  // Strobes are combinational off a register, so they carry no extra latency
  // and only change with their controller inputs or a clock edge.
  assign pc_write  = pc_update | (pc_s & cond_ex_q);
  assign reg_write = reg_w & cond_ex_q & ~no_write;
  assign mem_write = mem_w & cond_ex_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_result;
  logic        n_in, z_in, c_in, v_in;
  logic [3:0]  cond;
  logic        cond_latch;
  logic [1:0]  flag_w;
  logic        pc_update, pc_s, reg_w, mem_w, no_write;
  logic [15:0] alu_out;
  logic [3:0]  flags;
  logic        cond_ex;
  logic        pc_write, reg_write, mem_write;

  int checks   = 0;
  int failures = 0;

  cond_flag_unit #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_result (alu_result),
    .n_in       (n_in),
    .z_in       (z_in),
    .c_in       (c_in),
    .v_in       (v_in),
    .cond       (cond),
    .cond_latch (cond_latch),
    .flag_w     (flag_w),
    .pc_update  (pc_update),
    .pc_s       (pc_s),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .no_write   (no_write),
    .alu_out    (alu_out),
    .flags      (flags),
    .cond_ex    (cond_ex),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Force cond_ex=1 with AL, then load all four flags.
  task automatic set_flags(input logic [3:0] f);
    cond = 4'hE; cond_latch = 1'b1; flag_w = 2'b00;
    step();
    cond_latch = 1'b0;
    flag_w = 2'b11; {n_in, z_in, c_in, v_in} = f;
    step();
    flag_w = 2'b00;
  endtask

  task automatic test_reset();
    // Power-on reset values
    reset = 1'b1;
    step();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL por_flags got=%h exp=0", flags); end
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL por_cond_ex got=%b exp=0", cond_ex); end
    checks++; if (alu_out !== 16'h0000) begin failures++; $display("FAIL por_alu_out got=%h exp=0000", alu_out); end
    #2 reset = 1'b0;
    // Build up state, then reset asynchronously mid-cycle
    set_flags(4'b1111);
    alu_result = 16'h5555;
    step();
    checks++; if (flags !== 4'b1111 || cond_ex !== 1'b1 || alu_out !== 16'h5555) begin
      failures++; $display("FAIL reset_pre flags=%h cond_ex=%b alu_out=%h exp=f/1/5555", flags, cond_ex, alu_out);
    end
    reg_w = 1'b1;
    #1;
    checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL reset_pre_regw got=%b exp=1", reg_write); end
    reset = 1'b1;
    #1;
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_async_flags got=%h exp=0", flags); end
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL reset_async_cond_ex got=%b exp=0", cond_ex); end
    checks++; if (alu_out !== 16'h0000) begin failures++; $display("FAIL reset_async_alu_out got=%h exp=0000", alu_out); end
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_async_reg_write got=%b exp=0", reg_write); end
    checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL reset_async_pc_write got=%b exp=0", pc_write); end
    #1 reset = 1'b0;
    reg_w = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_aluout();
    alu_result = 16'h1234;
    step();
    checks++; if (alu_out !== 16'h1234) begin failures++; $display("FAIL alu_out_1 got=%h exp=1234", alu_out); end
    alu_result = 16'hABCD;
    #1;
    checks++; if (alu_out !== 16'h1234) begin failures++; $display("FAIL alu_out_hold got=%h exp=1234", alu_out); end
    step();
    checks++; if (alu_out !== 16'hABCD) begin failures++; $display("FAIL alu_out_2 got=%h exp=abcd", alu_out); end
    $display("test_aluout done");
  endtask

  task automatic test_flag_halves();
    // flags are 0000 after the reset test; make cond_ex=1
    cond = 4'hE; cond_latch = 1'b1;
    step();
    cond_latch = 1'b0;
    flag_w = 2'b10; {n_in, z_in, c_in, v_in} = 4'b1111;
    step();
    checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL halves_nz got=%b exp=1100", flags); end
    flag_w = 2'b01; {n_in, z_in, c_in, v_in} = 4'b0011;
    step();
    checks++; if (flags !== 4'b1111) begin failures++; $display("FAIL halves_cv got=%b exp=1111", flags); end
    // NE fails with Z=1 -> cond_ex=0 -> flags must hold
    flag_w = 2'b00; cond = 4'h1; cond_latch = 1'b1;
    step();
    cond_latch = 1'b0;
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL halves_ne got=%b exp=0", cond_ex); end
    flag_w = 2'b11; {n_in, z_in, c_in, v_in} = 4'b0000;
    step();
    flag_w = 2'b00;
    checks++; if (flags !== 4'b1111) begin failures++; $display("FAIL halves_hold got=%b exp=1111", flags); end
    $display("test_flag_halves done");
  endtask

  task automatic test_cond_sweep();
    logic [3:0]  pat [6];
    logic [15:0] exp_tbl [6];
    logic [15:0] e;
    pat[0] = 4'b1000; exp_tbl[0] = 16'hEA9A;
    pat[1] = 4'b0100; exp_tbl[1] = 16'hE6A9;
    pat[2] = 4'b0010; exp_tbl[2] = 16'hD5A6;
    pat[3] = 4'b1001; exp_tbl[3] = 16'hD65A;
    pat[4] = 4'b0110; exp_tbl[4] = 16'hE6A5;
    pat[5] = 4'b0001; exp_tbl[5] = 16'hEA6A;
    for (int p = 0; p < 6; p++) begin
      set_flags(pat[p]);
      checks++; if (flags !== pat[p]) begin failures++; $display("FAIL sweep_flags p=%0d got=%b exp=%b", p, flags, pat[p]); end
      e = exp_tbl[p];
      // cond_latch held high: every cycle reloads cond_ex
      cond_latch = 1'b1;
      for (int c = 0; c < 16; c++) begin
        cond = c[3:0];
        step();
        checks++; if (cond_ex !== e[c]) begin
          failures++; $display("FAIL sweep_cond flags=%b cond=%h got=%b exp=%b", pat[p], c, cond_ex, e[c]);
        end
      end
      cond_latch = 1'b0;
      $display("test_cond_sweep flags=%b done", pat[p]);
    end
  endtask

  task automatic test_gating();
    set_flags(4'b0000);
    cond = 4'h0; cond_latch = 1'b1;
    step();
    cond_latch = 1'b0;
    pc_s = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    #1;
    checks++; if ({pc_write, reg_write, mem_write} !== 3'b000) begin
      failures++; $display("FAIL gate_eq_fail got=%b exp=000", {pc_write, reg_write, mem_write});
    end
    pc_update = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL gate_pc_update got=%b exp=1", pc_write); end
    pc_update = 1'b0;
    set_flags(4'b0100);
    cond = 4'h0; cond_latch = 1'b1;
    step();
    cond_latch = 1'b0;
    checks++; if ({pc_write, reg_write, mem_write} !== 3'b111) begin
      failures++; $display("FAIL gate_eq_pass got=%b exp=111", {pc_write, reg_write, mem_write});
    end
    no_write = 1'b1;
    #1;
    checks++; if ({pc_write, reg_write, mem_write} !== 3'b101) begin
      failures++; $display("FAIL gate_no_write got=%b exp=101", {pc_write, reg_write, mem_write});
    end
    no_write = 1'b0; pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    $display("test_gating done");
  endtask

  task automatic test_simultaneous();
    set_flags(4'b0000);
    cond = 4'h0; cond_latch = 1'b1;   // EQ with Z=0 -> cond_ex=0
    step();
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL simul_setup got=%b exp=0", cond_ex); end
    cond = 4'hE; cond_latch = 1'b1; flag_w = 2'b11; {n_in, z_in, c_in, v_in} = 4'b1111;
    step();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL simul_old_gate got=%b exp=0000", flags); end
    checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL simul_latch got=%b exp=1", cond_ex); end
    cond_latch = 1'b0; {n_in, z_in, c_in, v_in} = 4'b1010;
    step();
    checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL simul_next_write got=%b exp=1010", flags); end
    // Old cond_ex=1 lets the write through; EQ sees pre-update Z=0 and fails
    cond = 4'h0; cond_latch = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0100;
    step();
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL simul_write_thru got=%b exp=0100", flags); end
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL simul_pre_flags got=%b exp=0", cond_ex); end
    cond_latch = 1'b0; flag_w = 2'b00;
    $display("test_simultaneous done");
  endtask

  initial begin
    reset = 1'b1; alu_result = '0;
    n_in = 1'b0; z_in = 1'b0; c_in = 1'b0; v_in = 1'b0;
    cond = 4'h0; cond_latch = 1'b0; flag_w = 2'b00;
    pc_update = 1'b0; pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    test_reset();
    test_aluout();
    test_flag_halves();
    test_cond_sweep();
    test_gating();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
